instr_encoder: RTL and testbench

- Writer side of the instruction path: accepts decoded instruction fields over a valid/ready handshake and assembles 32-bit MIPS instruction words.
- Writes each word into instruction memory at sequential word addresses.
- Covers exactly the opcode classes the control decoder recognises: R-format, beq, addi, slti.
- Used by the testbench/loader to build programs that the single-cycle CPU then fetches.

---
 rtl/instr_encoder.sv | 98 +++++++++
 tb/tb_instr_encoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS R/beq/addi/slti words from field bundles and writes them to sequential memory words.
// Define INSTR_ENC_BEQ_REL_EN to treat beq imm_i as an absolute target address and encode it PC-relative.
module instr_encoder #(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);
    localparam logic [1:0] IDLE = 2'd0, ENC = 2'd1, WRITE = 2'd2;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    logic [1:0]        r_state;
    logic [2:0]        r_kind;
    logic [4:0]        r_rs, r_rt, r_rd, r_shamt;
    logic [5:0]        r_funct;
    logic [15:0]       r_imm;
    logic [ADDR_W-1:0] r_ptr, r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_data;
    logic              r_err;
    logic              w_valid_kind;
    logic [5:0]        w_op;
    logic [15:0]       w_imm;
    logic [31:0]       w_word;
    always_comb begin
        w_valid_kind = r_kind >= 3'd1 && r_kind <= 3'd4;
        w_op = r_kind == 3'd1 ? 6'd4 : r_kind == 3'd3 ? 6'd8 : 6'd10;
`ifdef INSTR_ENC_BEQ_REL_EN
        w_imm = r_kind == 3'd1 ? r_imm - 16'(r_ptr) - 16'd1 : r_imm;
`else
        w_imm = r_imm;
`endif
        w_word = r_kind == 3'd2 ? {6'd0, r_rs, r_rt, r_rd, r_shamt, r_funct} : {w_op, r_rs, r_rt, w_imm};
    end
    // count never exceeds 2^ADDR_W, so its top bit alone marks full
    assign full_o     = r_count[ADDR_W];
    assign ready_o    = r_state == IDLE && !full_o;
    assign mem_we_o   = r_state == WRITE && !rst_i && !clr_i;
    assign mem_addr_o = r_addr;
    assign mem_data_o = r_data;
    assign count_o    = r_count;
    assign err_o      = r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= BASE;
            r_addr  <= BASE;
            r_count <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (clr_i) begin
            r_state <= IDLE;
            r_ptr   <= BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (valid_i && ready_o) begin
                r_kind  <= kind_i;
                r_rs    <= rs_i;
                r_rt    <= rt_i;
                r_rd    <= rd_i;
                r_shamt <= shamt_i;
                r_funct <= funct_i;
                r_imm   <= imm_i;
                r_state <= ENC;
            end
        end else if (r_state == ENC) begin
            if (w_valid_kind) begin
                r_data  <= w_word;
                r_addr  <= r_ptr;
                r_state <= WRITE;
            end else begin
                r_err   <= 1'b1;
                r_state <= IDLE;
            end
        end else begin
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(1);
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven check of instr_encoder (ADDR_W=2) plus full, clear and reset corner sequences.
module tb_instr_encoder;
    logic        clk_i = 1'b0, rst_i = 1'b1, clr_i = 1'b0, valid_i = 1'b0;
    logic        ready_o, mem_we_o, full_o, err_o;
    logic [2:0]  kind_i = '0;
    logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0, shamt_i = '0;
    logic [5:0]  funct_i = '0;
    logic [15:0] imm_i = '0;
    logic [1:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  count_o;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [2:0]  count;
        logic        err, full;
    } vec_t;
    vec_t vecs[5];

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(ready_o),
        .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .count_o(count_o), .full_o(full_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] k, input logic [15:0] imm);
        kind_i = k; rs_i = 5'd1; rt_i = 5'd2; rd_i = 5'd3; shamt_i = 5'd0; funct_i = 6'h20; imm_i = imm;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk($sformatf("v%0d ready_wait", i), {31'd0, ready_o}, 32'd1);
        kind_i = v.kind; rs_i = v.rs; rt_i = v.rt; rd_i = v.rd; shamt_i = v.shamt; funct_i = v.funct; imm_i = v.imm;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        chk($sformatf("v%0d enc_ready", i), {31'd0, ready_o}, 32'd0);
        chk($sformatf("v%0d enc_we", i), {31'd0, mem_we_o}, 32'd0);
        @(negedge clk_i);
        chk($sformatf("v%0d wr_we", i), {31'd0, mem_we_o}, {31'd0, v.we});
        chk($sformatf("v%0d wr_ready", i), {31'd0, ready_o}, {31'd0, !v.we});
        if (v.we) begin
            chk($sformatf("v%0d wr_addr", i), {30'd0, mem_addr_o}, {30'd0, v.addr});
            chk($sformatf("v%0d wr_data", i), mem_data_o, v.data);
        end
        @(negedge clk_i);
        chk($sformatf("v%0d post_we", i), {31'd0, mem_we_o}, 32'd0);
        chk($sformatf("v%0d hold_addr", i), {30'd0, mem_addr_o}, {30'd0, v.addr});
        chk($sformatf("v%0d hold_data", i), mem_data_o, v.data);
        chk($sformatf("v%0d count", i), {29'd0, count_o}, {29'd0, v.count});
        chk($sformatf("v%0d err", i), {31'd0, err_o}, {31'd0, v.err});
        chk($sformatf("v%0d full", i), {31'd0, full_o}, {31'd0, v.full});
        chk($sformatf("v%0d ready", i), {31'd0, ready_o}, {31'd0, !v.full});
    endtask

    initial begin
        vecs[0] = '{3'd3, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1, 2'd0, 32'h20010005, 3'd1, 1'b0, 1'b0};
        vecs[1] = '{3'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b1, 2'd1, 32'h00221820, 3'd2, 1'b0, 1'b0};
        vecs[2] = '{3'd7, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h1234, 1'b0, 2'd1, 32'h00221820, 3'd2, 1'b1, 1'b0};
`ifdef INSTR_ENC_BEQ_REL_EN
        vecs[3] = '{3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0000, 1'b1, 2'd2, 32'h1022FFFD, 3'd3, 1'b1, 1'b0};
`else
        vecs[3] = '{3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 1'b1, 2'd2, 32'h10220003, 3'd3, 1'b1, 1'b0};
`endif
        vecs[4] = '{3'd4, 5'd1, 5'd4, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1, 2'd3, 32'h2824FFFF, 3'd4, 1'b1, 1'b1};

        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst ready", {31'd0, ready_o}, 32'd1);
        chk("rst we", {31'd0, mem_we_o}, 32'd0);
        chk("rst addr", {30'd0, mem_addr_o}, 32'd0);
        chk("rst data", mem_data_o, 32'd0);
        chk("rst count", {29'd0, count_o}, 32'd0);
        chk("rst full", {31'd0, full_o}, 32'd0);
        chk("rst err", {31'd0, err_o}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // a fifth bundle offered while full must be ignored
        kind_i = 3'd3; imm_i = 16'h0001; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("full no_we", {31'd0, mem_we_o}, 32'd0);
        end
        valid_i = 1'b0;
        chk("full count", {29'd0, count_o}, 32'd4);
        chk("full ready", {31'd0, ready_o}, 32'd0);
        chk("full flag", {31'd0, full_o}, 32'd1);

        clr_i = 1'b1;
        @(posedge clk_i);
        #1 clr_i = 1'b0;
        @(negedge clk_i);
        chk("clr count", {29'd0, count_o}, 32'd0);
        chk("clr full", {31'd0, full_o}, 32'd0);
        chk("clr err", {31'd0, err_o}, 32'd0);
        chk("clr ready", {31'd0, ready_o}, 32'd1);
        run_vec(5, '{3'd3, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0007, 1'b1, 2'd0, 32'h20010007, 3'd1, 1'b0, 1'b0});

        // clear during the write cycle aborts the strobe
        drive(3'd3, 16'h0009);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("clrw we_before", {31'd0, mem_we_o}, 32'd1);
        clr_i = 1'b1;
        #1 chk("clrw we_gated", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk_i);
        #1 clr_i = 1'b0;
        @(negedge clk_i);
        chk("clrw count", {29'd0, count_o}, 32'd0);
        chk("clrw ready", {31'd0, ready_o}, 32'd1);

        drive(3'd0, 16'h0000);
        repeat (3) @(negedge clk_i);
        chk("inv err", {31'd0, err_o}, 32'd1);
        chk("inv count", {29'd0, count_o}, 32'd0);

        drive(3'd2, 16'h0000);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rstw we_before", {31'd0, mem_we_o}, 32'd1);
        chk("rstw data_before", mem_data_o, 32'h00221820);
        rst_i = 1'b1;
        #1 chk("rstw we_gated", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstw ready", {31'd0, ready_o}, 32'd1);
        chk("rstw we", {31'd0, mem_we_o}, 32'd0);
        chk("rstw addr", {30'd0, mem_addr_o}, 32'd0);
        chk("rstw data", mem_data_o, 32'd0);
        chk("rstw count", {29'd0, count_o}, 32'd0);
        chk("rstw full", {31'd0, full_o}, 32'd0);
        chk("rstw err", {31'd0, err_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
